// File: rtl/arith_pipe.sv
// rtl/arith_pipe.sv - pipelined add/sub/accumulate unit with global-stall valid/ready handshake.
// Optional build macro ARITH_PIPE_SAT_EN selects saturating results instead of modulo wrap.
module arith_pipe #(
  parameter int W   = 10,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [LAT-1:0]        r_vld;
  logic [LAT-1:0][W-1:0] r_y;
  logic [LAT-1:0]        r_ovf;
  logic [W-1:0]          r_acc;

  logic         w_advance;
  logic         w_accept;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W:0]   w_acc_sum;
  logic [W-1:0] w_res;
  logic         w_res_ovf;
  logic         w_acc_wr;

  // One stall signal freezes every stage, so bubbles are kept in place.
  assign w_advance = !r_vld[LAT-1] || out_ready;
  assign in_ready  = rst_n && w_advance;
  assign w_accept  = in_valid && in_ready;

  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, a};
  assign w_acc_wr  = w_accept && (op == OP_ACC || op == OP_CLR);

  always_comb begin
    w_res     = '0;
    w_res_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        w_res_ovf = w_sum[W];
`ifdef ARITH_PIPE_SAT_EN
        w_res     = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
`else
        w_res     = w_sum[W-1:0];
`endif
      end
      OP_SUB: begin
        // The extra top bit of the W+1 difference is the unsigned borrow (a < b).
        w_res_ovf = w_diff[W];
`ifdef ARITH_PIPE_SAT_EN
        w_res     = w_diff[W] ? '0 : w_diff[W-1:0];
`else
        w_res     = w_diff[W-1:0];
`endif
      end
      OP_ACC: begin
        w_res_ovf = w_acc_sum[W];
`ifdef ARITH_PIPE_SAT_EN
        w_res     = w_acc_sum[W] ? {W{1'b1}} : w_acc_sum[W-1:0];
`else
        w_res     = w_acc_sum[W-1:0];
`endif
      end
      default: begin
        w_res     = '0;
        w_res_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_acc_wr) begin
      r_acc <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_y   <= '0;
      r_ovf <= '0;
    end else if (w_advance) begin
      r_vld[0] <= w_accept;
      r_y[0]   <= w_res;
      r_ovf[0] <= w_res_ovf;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_y[i]   <= r_y[i-1];
        r_ovf[i] <= r_ovf[i-1];
      end
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign y         = r_y[LAT-1];
  assign ovf       = r_ovf[LAT-1];

endmodule

// File: tb/tb_arith_pipe.sv
// tb/tb_arith_pipe.sv - scoreboard bench for arith_pipe (W=10, LAT=2) with directed vectors.
module tb_arith_pipe;
  localparam int W   = 10;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] y;
  logic         ovf;

  arith_pipe #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [W:0] sb[$];
  int pop_cyc[$];

`ifdef ARITH_PIPE_SAT_EN
  localparam int E_ADD_BIG = 1023;
  localparam int E_SUB_NEG = 0;
  localparam int E_ADD_MAX = 1023;
`else
  localparam int E_ADD_BIG = 76;
  localparam int E_SUB_NEG = 1022;
  localparam int E_ADD_MAX = 0;
`endif

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("result_y", int'(y), int'(e[W-1:0]));
        check("result_ovf", int'(ovf), int'(e[W]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [1:0] o, input int av, input int bv, input int ey, input int eo);
    int n;
    logic [W:0] e;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = av[W-1:0];
    b = bv[W-1:0];
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e = {eo[0], ey[W-1:0]};
      sb.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int stale;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y", int'(y), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;

    // Latency: valid two edges after accept
    send(2'b00, 600, 500, E_ADD_BIG, 1);
    @(negedge clk);
    check("lat_early", int'(out_valid), 0);
    @(negedge clk);
    check("lat_on_time", int'(out_valid), 1);
    drain();

    send(2'b01, 5, 7, E_SUB_NEG, 1);
    send(2'b01, 7, 5, 2, 0);
    send(2'b00, 3, 4, 7, 0);
    send(2'b00, 1023, 1, E_ADD_MAX, 1);
    send(2'b01, 1023, 1023, 0, 0);
    drain();

    // Accumulator chain back to back, one result per cycle
    pop_cyc.delete();
    send(2'b11, 55, 66, 0, 0);
    send(2'b10, 100, 0, 100, 0);
    send(2'b10, 200, 0, 300, 0);
    send(2'b10, 300, 0, 600, 0);
    drain();
    check("acc_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) check("acc_throughput", pop_cyc[3] - pop_cyc[0], 3);

    // Stall with full pipe
    out_ready = 1'b0;
    send(2'b00, 1, 1, 2, 0);
    send(2'b00, 2, 2, 4, 0);
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b00;
    a = 10'd3;
    b = 10'd3;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_y_hold", int'(y), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    sb.push_back({1'b0, 10'd6});
    #1 in_valid = 1'b0;
    drain();

    // Reset with results in flight
    out_ready = 1'b0;
    send(2'b10, 9, 0, 609, 0);
    send(2'b10, 9, 0, 618, 0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_in_ready", int'(in_ready), 0);
    check("async_rst_y", int'(y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);
    send(2'b10, 7, 0, 7, 0);
    drain();

    repeat (5) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
